// File: rtl/dllp_rx_decode.sv
// -----------------------------------------------------------------------------
// dllp_rx_decode
//
// Receives 6-byte PCIe DLLPs over a 32-bit AXI-Stream link, checks the 16-bit
// DLLP CRC and decodes good DLLPs into Ack/Nak, flow-control or "other" events.
//
// Frame layout:
//   beat 1 : body bytes 0..3, tkeep=1111, tlast=0
//   beat 2 : CRC byte 4 in tdata[7:0], byte 5 in tdata[15:8], tkeep=0011, tlast=1
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   link_up_i                physical link up; low flushes any partial frame
//   s_dllp_axis_*            AXI-Stream sink; tuser[0] flags a physical-layer error
//   ack_valid_o/_is_nak_o/_seq_o          one-cycle Ack/Nak event plus payload
//   fc_valid_o/_kind_o/_class_o/_vc_o/_hdr_o/_data_o
//                                         one-cycle flow-control event plus payload
//   other_valid_o/_type_o    one-cycle event for any other good DLLP type
//   crc_err_cnt_o            saturating count of CRC failures
//   malformed_cnt_o          saturating count of malformed / errored frames
//
// Payload outputs hold their last decoded value between pulses. Pulses appear
// in the cycle after the accepted CRC beat.
// -----------------------------------------------------------------------------
module dllp_rx_decode #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  link_up_i,

  input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
  input  logic                  s_dllp_axis_tvalid,
  input  logic                  s_dllp_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
  output logic                  s_dllp_axis_tready,

  output logic                  ack_valid_o,
  output logic                  ack_is_nak_o,
  output logic [11:0]           ack_seq_o,

  output logic                  fc_valid_o,
  output logic [1:0]            fc_kind_o,
  output logic [1:0]            fc_class_o,
  output logic [2:0]            fc_vc_o,
  output logic [7:0]            fc_hdr_o,
  output logic [11:0]           fc_data_o,

  output logic                  other_valid_o,
  output logic [7:0]            other_type_o,

  output logic [15:0]           crc_err_cnt_o,
  output logic [15:0]           malformed_cnt_o
);

  // ---------------------------------------------------------------------------
  // Elaboration guard: the beat layout is hard-wired for a 4-byte stream.
  // ---------------------------------------------------------------------------
  generate
    if (DATA_WIDTH != 32 || KEEP_WIDTH != 4) begin : g_bad_width
      $error("dllp_rx_decode supports only DATA_WIDTH=32 with KEEP_WIDTH=4");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWaitCrc = 2'd1;
  localparam logic [1:0] StDiscard = 2'd2;

  localparam logic [KEEP_WIDTH-1:0] KeepBody = KEEP_WIDTH'(4'b1111);
  localparam logic [KEEP_WIDTH-1:0] KeepCrc  = KEEP_WIDTH'(4'b0011);

  localparam logic [15:0] CntMax = 16'hFFFF;

  localparam logic [1:0] KindInitFc1 = 2'd0;
  localparam logic [1:0] KindInitFc2 = 2'd1;
  localparam logic [1:0] KindUpdate  = 2'd2;

  // ---------------------------------------------------------------------------
  // DLLP CRC-16 (poly 100Bh, seed FFFFh), bit 0 of byte 0 shifted in first.
  // Returns the value expected on tdata[15:0] of the CRC beat: the complemented
  // remainder with bits 15..8 bit-reversed into byte 4 and 7..0 into byte 5.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] dllp_crc(input logic [31:0] body);
    logic [15:0] crc;
    logic [15:0] wire_order;
    logic        fb;
    crc = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb  = crc[15] ^ body[i];
      crc = {crc[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    crc = ~crc;
    for (int i = 0; i < 8; i++) begin
      wire_order[i]     = crc[15 - i];
      wire_order[8 + i] = crc[7 - i];
    end
    return wire_order;
  endfunction

  // ---------------------------------------------------------------------------
  // Beat classification
  // ---------------------------------------------------------------------------
  logic        beat;
  logic        phy_err;
  logic        body_beat;
  logic        crc_beat;
  logic        crc_ok;
  logic        unused_user;

  logic [1:0]  state_q, state_d;
  logic [31:0] body_q, body_d;

  // The sink never stalls; it only drops tready while held in reset.
  assign s_dllp_axis_tready = ~rst_i;

  assign beat    = s_dllp_axis_tvalid & s_dllp_axis_tready;
  assign phy_err = s_dllp_axis_tuser[0];

  // Only tuser[0] carries meaning; the remaining sideband bits are ignored.
  assign unused_user = ^s_dllp_axis_tuser;

  // A beat flagged with a physical-layer error never matches a frame position,
  // so it falls into the malformed path exactly once per frame.
  assign body_beat = (s_dllp_axis_tkeep == KeepBody) & ~s_dllp_axis_tlast & ~phy_err;
  assign crc_beat  = (s_dllp_axis_tkeep == KeepCrc) & s_dllp_axis_tlast & ~phy_err;
  assign crc_ok    = (s_dllp_axis_tdata[15:0] == dllp_crc(body_q));

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  logic frame_good;
  logic crc_err_inc;
  logic malformed_inc;

  always_comb begin
    state_d       = state_q;
    body_d        = body_q;
    frame_good    = 1'b0;
    crc_err_inc   = 1'b0;
    malformed_inc = 1'b0;

    if (!link_up_i) begin
      // Link down: drop any partial frame, accept and ignore traffic.
      state_d = StIdle;
    end else if (beat) begin
      case (state_q)
        StIdle: begin
          if (body_beat) begin
            state_d = StWaitCrc;
            body_d  = s_dllp_axis_tdata;
          end else begin
            malformed_inc = 1'b1;
            state_d       = s_dllp_axis_tlast ? StIdle : StDiscard;
          end
        end

        StWaitCrc: begin
          if (crc_beat) begin
            state_d = StIdle;
            if (crc_ok) begin
              frame_good = 1'b1;
            end else begin
              crc_err_inc = 1'b1;
            end
          end else begin
            malformed_inc = 1'b1;
            state_d       = s_dllp_axis_tlast ? StIdle : StDiscard;
          end
        end

        StDiscard: begin
          if (s_dllp_axis_tlast) begin
            state_d = StIdle;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // DLLP type decode (from the latched body; used only when frame_good)
  // ---------------------------------------------------------------------------
  logic [7:0] dllp_type;
  logic [7:0] body_byte1;
  logic [7:0] body_byte2;
  logic [7:0] body_byte3;
  logic       is_ack;
  logic       is_fc;
  logic [1:0] fc_kind;

  assign dllp_type  = body_q[7:0];
  assign body_byte1 = body_q[15:8];
  assign body_byte2 = body_q[23:16];
  assign body_byte3 = body_q[31:24];

  assign is_ack = (dllp_type == 8'h00) | (dllp_type == 8'h10);

  always_comb begin
    is_fc   = 1'b1;
    fc_kind = KindInitFc1;
    case (dllp_type[7:4])
      4'h4, 4'h5, 4'h6: fc_kind = KindInitFc1;
      4'hC, 4'hD, 4'hE: fc_kind = KindInitFc2;
      4'h8, 4'h9, 4'hA: fc_kind = KindUpdate;
      default:          is_fc   = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, event and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      body_q          <= 32'h0;
      ack_valid_o     <= 1'b0;
      ack_is_nak_o    <= 1'b0;
      ack_seq_o       <= 12'h0;
      fc_valid_o      <= 1'b0;
      fc_kind_o       <= 2'd0;
      fc_class_o      <= 2'd0;
      fc_vc_o         <= 3'd0;
      fc_hdr_o        <= 8'h0;
      fc_data_o       <= 12'h0;
      other_valid_o   <= 1'b0;
      other_type_o    <= 8'h0;
      crc_err_cnt_o   <= 16'h0;
      malformed_cnt_o <= 16'h0;
    end else begin
      state_q <= state_d;
      body_q  <= body_d;

      ack_valid_o   <= frame_good & is_ack;
      fc_valid_o    <= frame_good & ~is_ack & is_fc;
      other_valid_o <= frame_good & ~is_ack & ~is_fc;

      // Each payload group updates only with its own pulse and holds otherwise.
      if (frame_good && is_ack) begin
        ack_is_nak_o <= (dllp_type == 8'h10);
        ack_seq_o    <= {body_byte2[3:0], body_byte3};
      end

      if (frame_good && !is_ack && is_fc) begin
        fc_kind_o  <= fc_kind;
        fc_class_o <= dllp_type[5:4];
        fc_vc_o    <= dllp_type[2:0];
        fc_hdr_o   <= {body_byte1[5:0], body_byte2[7:6]};
        fc_data_o  <= {body_byte2[3:0], body_byte3};
      end

      if (frame_good && !is_ack && !is_fc) begin
        other_type_o <= dllp_type;
      end

      if (crc_err_inc && (crc_err_cnt_o != CntMax)) begin
        crc_err_cnt_o <= crc_err_cnt_o + 16'd1;
      end

      if (malformed_inc && (malformed_cnt_o != CntMax)) begin
        malformed_cnt_o <= malformed_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dllp_rx_decode.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dllp_rx_decode. A behavioural model tracks the
// expected counters and the last payload of each event group; every check
// compares the full observable output state against it.
// -----------------------------------------------------------------------------
module tb_dllp_rx_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_up;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic [4:0]  tuser;
  logic        tready;

  logic        ack_valid, ack_is_nak;
  logic [11:0] ack_seq;
  logic        fc_valid;
  logic [1:0]  fc_kind, fc_class;
  logic [2:0]  fc_vc;
  logic [7:0]  fc_hdr;
  logic [11:0] fc_data;
  logic        other_valid;
  logic [7:0]  other_type;
  logic [15:0] crc_err_cnt, malformed_cnt;

  always #5 clk = ~clk;

  dllp_rx_decode dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .link_up_i          (link_up),
    .s_dllp_axis_tdata  (tdata),
    .s_dllp_axis_tkeep  (tkeep),
    .s_dllp_axis_tvalid (tvalid),
    .s_dllp_axis_tlast  (tlast),
    .s_dllp_axis_tuser  (tuser),
    .s_dllp_axis_tready (tready),
    .ack_valid_o        (ack_valid),
    .ack_is_nak_o       (ack_is_nak),
    .ack_seq_o          (ack_seq),
    .fc_valid_o         (fc_valid),
    .fc_kind_o          (fc_kind),
    .fc_class_o         (fc_class),
    .fc_vc_o            (fc_vc),
    .fc_hdr_o           (fc_hdr),
    .fc_data_o          (fc_data),
    .other_valid_o      (other_valid),
    .other_type_o       (other_type),
    .crc_err_cnt_o      (crc_err_cnt),
    .malformed_cnt_o    (malformed_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Model state
  logic        e_ack_v, e_nak, e_fc_v, e_oth_v;
  logic [11:0] e_seq, e_data;
  logic [1:0]  e_kind, e_class;
  logic [2:0]  e_vc;
  logic [7:0]  e_hdr, e_otype;
  int          e_crc, e_mal;

  typedef logic [82:0] vec_t;

  function automatic vec_t obs_vec();
    return {ack_valid, ack_is_nak, ack_seq, fc_valid, fc_kind, fc_class, fc_vc, fc_hdr,
            fc_data, other_valid, other_type, crc_err_cnt, malformed_cnt};
  endfunction

  function automatic vec_t exp_vec();
    return {e_ack_v, e_nak, e_seq, e_fc_v, e_kind, e_class, e_vc, e_hdr,
            e_data, e_oth_v, e_otype, 16'(e_crc), 16'(e_mal)};
  endfunction

  // Expected tdata[15:0] of the CRC beat for a given body.
  function automatic logic [15:0] ref_crc(input logic [31:0] body);
    int crc;
    int rem;
    int b4;
    int b5;
    int byt;
    int top;
    int bit_in;
    crc = 'hFFFF;
    b4  = 0;
    b5  = 0;
    for (int n = 0; n < 4; n++) begin
      byt = int'((body >> (8 * n)) & 32'hFF);
      for (int j = 0; j < 8; j++) begin
        top    = (crc >> 15) & 1;
        bit_in = (byt >> j) & 1;
        crc    = (crc << 1) & 'hFFFF;
        if (top != bit_in) crc = crc ^ 'h100B;
      end
    end
    rem = crc ^ 'hFFFF;
    for (int j = 0; j < 8; j++) begin
      b4 = b4 | (((rem >> (15 - j)) & 1) << j);
      b5 = b5 | (((rem >> (7 - j)) & 1) << j);
    end
    return 16'(b5 * 256 + b4);
  endfunction

  task automatic model_reset();
    e_ack_v = 0; e_nak = 0; e_fc_v = 0; e_oth_v = 0;
    e_seq = 0; e_data = 0; e_kind = 0; e_class = 0; e_vc = 0;
    e_hdr = 0; e_otype = 0; e_crc = 0; e_mal = 0;
  endtask

  task automatic clear_pulses();
    e_ack_v = 0; e_fc_v = 0; e_oth_v = 0;
  endtask

  task automatic bump_crc();
    if (e_crc < 65535) e_crc++;
  endtask

  task automatic bump_mal();
    if (e_mal < 65535) e_mal++;
  endtask

  // Decode of a good DLLP straight from the type/field rules.
  task automatic model_good(input logic [31:0] body);
    int t, b1, b2, b3, hi;
    t  = int'(body & 32'hFF);
    b1 = int'((body >> 8) & 32'hFF);
    b2 = int'((body >> 16) & 32'hFF);
    b3 = int'((body >> 24) & 32'hFF);
    hi = t / 16;
    clear_pulses();
    if (t == 0 || t == 16) begin
      e_ack_v = 1;
      e_nak   = (t == 16);
      e_seq   = 12'((b2 % 16) * 256 + b3);
    end else if ((hi >= 4 && hi <= 6) || (hi >= 12 && hi <= 14) || (hi >= 8 && hi <= 10)) begin
      e_fc_v = 1;
      if (hi >= 4 && hi <= 6) begin
        e_kind = 0; e_class = 2'(hi - 4);
      end else if (hi >= 12) begin
        e_kind = 1; e_class = 2'(hi - 12);
      end else begin
        e_kind = 2; e_class = 2'(hi - 8);
      end
      e_vc   = 3'(t % 8);
      e_hdr  = 8'((b1 % 64) * 4 + b2 / 64);
      e_data = 12'((b2 % 16) * 256 + b3);
    end else begin
      e_oth_v = 1;
      e_otype = 8'(t);
    end
  endtask

  // One accepted beat; between beats the bus carries invalid garbage.
  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                            input logic u);
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tuser  = {4'($urandom), u};
    tvalid = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tdata  = $urandom;
    tkeep  = 4'($urandom);
    tlast  = 1'($urandom);
    tuser  = 5'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] pick_type();
    logic [7:0] types [16];
    types = '{8'h00, 8'h10, 8'h40, 8'h51, 8'h62, 8'hC0, 8'hD3, 8'hE7,
              8'h80, 8'h95, 8'hA2, 8'h20, 8'h30, 8'h70, 8'hF0, 8'hB1};
    if ($urandom_range(1, 0) == 1) return types[$urandom_range(15, 0)];
    return 8'($urandom);
  endfunction

  function automatic logic [31:0] rand_body();
    logic [31:0] r;
    r = $urandom;
    return {r[31:8], pick_type()};
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready: got %b want 0", tready);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", obs_vec(), exp_vec());
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tready !== 1'b1) begin
      errors++;
      $display("FAIL release_tready: got %b want 1", tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ack_directed();
    logic [31:0] body;
    body = 32'h2301_0000;
    drive_beat(body, 4'hF, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL ack_beat1_quiet: got %h want %h", obs_vec(), exp_vec());
    end
    gap(2);
    drive_beat({16'($urandom), ref_crc(body)}, 4'h3, 1'b1, 1'b0);
    model_good(body);
    checks++;
    if (ack_valid !== 1'b1 || ack_is_nak !== 1'b0 || ack_seq !== 12'h123) begin
      errors++;
      $display("FAIL ack_fields: got v=%b nak=%b seq=%h want v=1 nak=0 seq=123",
               ack_valid, ack_is_nak, ack_seq);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL ack_outputs: got %h want %h", obs_vec(), exp_vec());
    end
    gap(1);
    clear_pulses();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL ack_pulse_width: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fc_directed();
    logic [31:0] body;
    body = 32'h56C4_2A91;
    drive_beat(body, 4'hF, 1'b0, 1'b0);
    drive_beat({16'($urandom), ref_crc(body)}, 4'h3, 1'b1, 1'b0);
    model_good(body);
    checks++;
    if (fc_valid !== 1'b1 || fc_kind !== 2'd2 || fc_class !== 2'd1 || fc_vc !== 3'd1 ||
        fc_hdr !== 8'hAB || fc_data !== 12'h456) begin
      errors++;
      $display("FAIL fc_fields: got v=%b k=%0d c=%0d vc=%0d hdr=%h data=%h want 1 2 1 1 ab 456",
               fc_valid, fc_kind, fc_class, fc_vc, fc_hdr, fc_data);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL fc_outputs: got %h want %h", obs_vec(), exp_vec());
    end
    gap(1);
    clear_pulses();
  endtask

  task automatic test_crc_error();
    logic [31:0] body;
    body = 32'h2301_0000;
    drive_beat(body, 4'hF, 1'b0, 1'b0);
    drive_beat({16'h0, ref_crc(body) ^ 16'h0004}, 4'h3, 1'b1, 1'b0);
    bump_crc();
    checks++;
    if (crc_err_cnt !== 16'd1 || ack_valid !== 1'b0) begin
      errors++;
      $display("FAIL crc_error: got cnt=%h v=%b want cnt=0001 v=0", crc_err_cnt, ack_valid);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL crc_error_outputs: got %h want %h", obs_vec(), exp_vec());
    end
    gap(1);
  endtask

  task automatic test_three_beat();
    logic [31:0] body;
    body = 32'h2301_0000;
    drive_beat(body, 4'hF, 1'b0, 1'b0);
    drive_beat($urandom, 4'hF, 1'b0, 1'b0);
    drive_beat({16'h0, ref_crc(body)}, 4'h3, 1'b1, 1'b0);
    bump_mal();
    checks++;
    if (malformed_cnt !== 16'd1 || ack_valid !== 1'b0) begin
      errors++;
      $display("FAIL three_beat: got cnt=%h v=%b want cnt=0001 v=0", malformed_cnt, ack_valid);
    end
    body = 32'h56C4_2A91;
    drive_beat(body, 4'hF, 1'b0, 1'b0);
    drive_beat({16'h0, ref_crc(body)}, 4'h3, 1'b1, 1'b0);
    model_good(body);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL three_beat_recover: got %h want %h", obs_vec(), exp_vec());
    end
    gap(1);
    clear_pulses();
  endtask

  task automatic test_back_to_back();
    logic [31:0] body;
    for (int i = 0; i < 6; i++) begin
      body = rand_body();
      drive_beat(body, 4'hF, 1'b0, 1'b0);
      clear_pulses();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_beat1 %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      drive_beat({16'($urandom), ref_crc(body)}, 4'h3, 1'b1, 1'b0);
      model_good(body);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_frame %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    gap(1);
    clear_pulses();
  endtask

  task automatic test_random();
    logic [31:0] body;
    logic [15:0] crc;
    int          sel;
    for (int i = 0; i < 80; i++) begin
      body = rand_body();
      crc  = ref_crc(body);
      sel  = $urandom_range(6, 0);
      case (sel)
        0: begin
          drive_beat(body, 4'hF, 1'b0, 1'b0);
          gap($urandom_range(2, 0));
          drive_beat({16'($urandom), crc}, 4'h3, 1'b1, 1'b0);
          model_good(body);
        end
        1: begin
          drive_beat(body, 4'hF, 1'b0, 1'b0);
          gap($urandom_range(2, 0));
          drive_beat({16'($urandom), crc ^ (16'd1 << $urandom_range(15, 0))}, 4'h3, 1'b1, 1'b0);
          bump_crc();
        end
        2: begin
          drive_beat(body, 4'hF, 1'b0, 1'b1);
          gap($urandom_range(2, 0));
          drive_beat({16'($urandom), crc}, 4'h3, 1'b1, 1'b0);
          bump_mal();
        end
        3: begin
          drive_beat(body, 4'hF, 1'b0, 1'b0);
          drive_beat({16'($urandom), crc}, 4'h3, 1'b1, 1'b1);
          bump_mal();
        end
        4: begin
          drive_beat(body, 4'hF, 1'b0, 1'b0);
          drive_beat($urandom, 4'hF, 1'b0, 1'b0);
          gap($urandom_range(2, 0));
          drive_beat({16'($urandom), crc}, 4'h3, 1'b1, 1'b0);
          bump_mal();
        end
        5: begin
          drive_beat(body, 4'hF, 1'b1, 1'b0);
          bump_mal();
        end
        default: begin
          drive_beat({16'($urandom), crc}, 4'h3, 1'b1, 1'b0);
          bump_mal();
        end
      endcase
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_frame %0d sel=%0d body=%h: got %h want %h",
                 i, sel, body, obs_vec(), exp_vec());
      end
      gap(1);
      clear_pulses();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_idle %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_link_down();
    logic [31:0] body;
    logic [31:0] body2;
    body  = 32'h56C4_2A91;
    body2 = 32'h2301_0010;
    drive_beat(body, 4'hF, 1'b0, 1'b0);
    link_up = 1'b0;
    gap(1);
    drive_beat(body2, 4'hF, 1'b0, 1'b0);
    drive_beat({16'h0, ref_crc(body2)}, 4'h3, 1'b1, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || tready !== 1'b1) begin
      errors++;
      $display("FAIL link_down_ignore: got %h rdy=%b want %h rdy=1", obs_vec(), tready, exp_vec());
    end
    drive_beat($urandom, 4'hF, 1'b1, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL link_down_counters: got %h want %h", obs_vec(), exp_vec());
    end
    link_up = 1'b1;
    // The partial frame from before link-down is gone, so its CRC beat is stray.
    drive_beat({16'h0, ref_crc(body)}, 4'h3, 1'b1, 1'b0);
    bump_mal();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL link_up_stray: got %h want %h", obs_vec(), exp_vec());
    end
    drive_beat(body2, 4'hF, 1'b0, 1'b0);
    drive_beat({16'h0, ref_crc(body2)}, 4'h3, 1'b1, 1'b0);
    model_good(body2);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL link_up_good: got %h want %h", obs_vec(), exp_vec());
    end
    gap(1);
    clear_pulses();
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] body;
    body = 32'h2301_0000;
    drive_beat(body, 4'hF, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== exp_vec() || tready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got %h rdy=%b want %h rdy=0", obs_vec(), tready, exp_vec());
    end
    rst = 1'b0;
    drive_beat({16'h0, ref_crc(body)}, 4'h3, 1'b1, 1'b0);
    bump_mal();
    checks++;
    if (malformed_cnt !== 16'd1 || ack_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_stray: got cnt=%h v=%b want cnt=0001 v=0", malformed_cnt, ack_valid);
    end
    drive_beat(body, 4'hF, 1'b0, 1'b0);
    drive_beat({16'h0, ref_crc(body)}, 4'h3, 1'b1, 1'b0);
    model_good(body);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL mid_reset_good: got %h want %h", obs_vec(), exp_vec());
    end
    gap(1);
    clear_pulses();
  endtask

  // Single-beat tlast frames are malformed and cost one cycle each, which keeps
  // driving a counter into saturation cheap.
  task automatic test_saturation();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tkeep  = 4'hF;
    tlast  = 1'b1;
    tuser  = 5'h0;
    tvalid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      tdata = $urandom;
      @(posedge clk);
      #1;
    end
    e_mal = 65535;
    checks++;
    if (malformed_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: got %h want ffff", malformed_cnt);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL sat_hold: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst     = 1'b1;
    link_up = 1'b1;
    tvalid  = 1'b0;
    tdata   = '0;
    tkeep   = '0;
    tlast   = 1'b0;
    tuser   = '0;
    model_reset();
    test_reset();
    test_ack_directed();
    test_fc_directed();
    test_crc_error();
    test_three_beat();
    test_back_to_back();
    test_random();
    test_link_down();
    test_reset_mid_frame();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
